pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
// Pipelined successor of the single-cycle opcode decoder: decodes the ID-stage opcode into a
// control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Adds
// I-type/JAL/JALR/LUI/AUIPC decode, load-use stall, branch flush and a parametrised memory
// wait-state counter. Sits beside the datapath pipeline registers; the PC/IF-ID logic obeys stall/flush.
// PARAMETERS
// REG_ADDR_W    5  register-index width
// MEM_WAIT_CYC  0  extra cycles a load/store holds the pipeline in MEM (0 = no wait states)
// EN_JUMP       1  1: decode JAL/JALR/LUI/AUIPC; 0: those opcodes decode as bubble (ill-op)
// PORTS
// clk             in   1           clock, rising edge
// reset           in   1           asynchronous, active-low reset
// id_valid        in   1           ID holds a real instruction
// id_opcode       in   7           instr[6:0]
// id_rs1/rs2/rd   in   REG_ADDR_W  ID register indices
// ex_taken        in   1           EX branch/jump resolved taken (datapath comparator)
// stall_if_id     out  1           hold PC and IF/ID
// flush_if_id     out  1           kill IF/ID content
// ill_op          out  1           combinational: id_valid and unrecognised opcode
// ex_valid,ex_alusrc,ex_branch,ex_jump  out 1; ex_aluop out 2; ex_rd out REG_ADDR_W
// mem_valid,mem_memread,mem_memwrite,mem_memtoreg,mem_regwrite out 1; mem_rd out REG_ADDR_W
// wb_valid,wb_regwrite,wb_memtoreg out 1; wb_rd out REG_ADDR_W
// BEHAVIOUR
// - Reset (reset=0): every registered output and the FSM/counter = 0 (all stages bubbles).
// - Decode: R 0110011: RegWrite, ALUOp=10. I 0010011: ALUSrc, RegWrite, ALUOp=11.
//   LW 0000011: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=00. SW 0100011: ALUSrc, MemWrite, ALUOp=00.
//   BR 1100011: Branch, ALUOp=01. JAL/JALR/LUI/AUIPC: RegWrite, ALUOp=00; Jump for JAL/JALR;
//   ALUSrc for JALR/LUI/AUIPC. Any other opcode: all-zero bundle, valid=0.
// - Uses: rs1 by all except LUI/AUIPC/JAL; rs2 only by R/SW/BR. Index 0 never causes hazards.
// - Bubble = valid=0 with every control bit 0; a stage's controls are 0 whenever valid=0.
// - mem_hold (memory FSM below), load_use = ex_valid & mem-read-in-EX & ex_rd!=0 &
//   ex_rd matches a used rs; flush = ex_valid & (ex_branch|ex_jump) & ex_taken.
// - Priority per cycle: mem_hold > flush > load_use.
//   mem_hold: ID/EX, EX/MEM hold; MEM/WB <= bubble; stall_if_id=1; flush_if_id=0.
//   flush: flush_if_id=1; ID/EX <= bubble; EX->MEM, MEM->WB advance; stall_if_id=0.
//   load_use: stall_if_id=1; ID/EX <= bubble; EX->MEM, MEM->WB advance.
//   else: all stages advance, ID/EX <= decode (id_valid gated).
// - Latency: ID decode visible on ex_* 1 cycle later, mem_* 2, wb_* 3 (no hold).
// - Memory FSM (only if MEM_WAIT_CYC>0): states M_IDLE, M_WAIT; cnt width $clog2(MEM_WAIT_CYC+1), min 1.
//   M_IDLE & mem_valid & (mem_memread|mem_memwrite): mem_hold=1, cnt<=MEM_WAIT_CYC-1, ->M_WAIT.
//   M_WAIT: mem_hold=(cnt!=0); cnt!=0: cnt--; cnt==0: op advances, ->M_IDLE.
//   Net: each load/store asserts mem_hold for exactly MEM_WAIT_CYC cycles; back-to-back ops each pay.
//   MEM_WAIT_CYC=0: FSM absent, mem_hold tied 0.
// - Simultaneous flush+load_use: flush wins (the stalled instruction is squashed anyway).
// - Reset mid-hold: FSM to M_IDLE, cnt 0, all stages bubbles immediately (async).
// STRUCTURE
// - riscv_ctrl_pkg: opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, LUI, AUIPC),
//   aluop_e enum {ALU_ADD=2'b00, ALU_BR=2'b01, ALU_R=2'b10, ALU_I=2'b11}, ctrl_t packed
//   struct {valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop}.
// - Sub-module ctrl_decode: combinational opcode -> ctrl_t + uses_rs1/uses_rs2/ill_op.
// - pipe_ctrl_unit: hazard logic, memory FSM, three ctrl_t + rd stage registers.
// TESTING
// 1 Reset low mid-stream with MEM_WAIT_CYC=2 during hold -> all outputs 0 same cycle; first
//   instr after release is on ex_* 1 cycle after issue.
// 2 R(rd=3) then I(rs1=3) -> no stall; ex_aluop 10 then 11; wb_regwrite=1 for both on cycles 3/4.
// 3 LW rd=5 then R rs2=5 -> stall_if_id=1 one cycle, ex_valid=0 bubble; LW rd=0 then rs1=0 -> no stall.
// 4 BR in EX with ex_taken=1 while ID has LW-dependent instr -> flush_if_id=1, stall_if_id=0, ex bubble.
// 5 MEM_WAIT_CYC=3, SW then LW back-to-back -> stall_if_id high 3 cycles per op (6 total),
//   wb_valid=0 during holds; LW reaches WB with memtoreg=1.
// 6 Opcode 7'b1111111 and EN_JUMP=0 with JAL -> ill_op=1, ex_valid=0, no RegWrite downstream.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path types for the pipelined decoder: opcodes, ALU op encoding,
// per-stage control bundles and memory wait-state FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   valid;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   jump;
    aluop_e aluop;
  } ctrl_t;

  // Later stages only carry the bits they still act on.
  typedef struct packed {
    logic valid;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the ID-stage control bundle, which source
// registers the instruction actually reads, and the illegal-opcode flag.
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int EN_JUMP = 1
) (
  input  logic       id_valid,
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       ill_op
);

  logic known;

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    known    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      R_TYPE: begin
        ctrl.regwrite = 1'b1; ctrl.aluop = ALU_R;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      I_TYPE: begin
        ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; ctrl.aluop = ALU_I;
        uses_rs1 = 1'b1;
      end
      LW: begin
        ctrl.alusrc = 1'b1; ctrl.memread = 1'b1; ctrl.memtoreg = 1'b1; ctrl.regwrite = 1'b1;
        uses_rs1 = 1'b1;
      end
      SW: begin
        ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      BR: begin
        ctrl.branch = 1'b1; ctrl.aluop = ALU_BR;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      JAL:   if (EN_JUMP != 0) begin ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; end
             else known = 1'b0;
      JALR:  if (EN_JUMP != 0) begin
               ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; ctrl.alusrc = 1'b1; uses_rs1 = 1'b1;
             end else known = 1'b0;
      LUI, AUIPC: if (EN_JUMP != 0) begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; end
                  else known = 1'b0;
      default: known = 1'b0;
    endcase
    // A non-instruction reads no registers, so it can never trigger a load-use stall.
    if (id_valid && known) begin
      ctrl.valid = 1'b1;
    end else begin
      ctrl     = CTRL_BUBBLE;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
    ill_op = id_valid && !known;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and generates load-use stall, taken-branch flush and memory wait-state holds.
module pipe_ctrl_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_CYC = 0,
  parameter int EN_JUMP      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_taken,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  ill_op,
  output logic                  ex_valid,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  mem_memtoreg,
  output logic                  mem_regwrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  ctrl_t                 dec_ctrl, id_ex;
  mem_ctrl_t             ex_mem;
  wb_ctrl_t              mem_wb;
  logic [REG_ADDR_W-1:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic                  uses_rs1, uses_rs2;
  logic                  mem_hold, load_use, flush;

  ctrl_decode #(.EN_JUMP(EN_JUMP)) u_decode (
    .id_valid (id_valid),
    .opcode   (id_opcode),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .ill_op   (ill_op)
  );

  assign load_use = id_ex.valid && id_ex.memread && (id_ex_rd != '0) &&
                    ((uses_rs1 && (id_rs1 == id_ex_rd)) || (uses_rs2 && (id_rs2 == id_ex_rd)));
  assign flush    = id_ex.valid && (id_ex.branch || id_ex.jump) && ex_taken;

  // Flush beats load-use: the instruction that would stall is squashed anyway.
  assign stall_if_id = mem_hold || (!flush && load_use);
  assign flush_if_id = !mem_hold && flush;

  generate
    if (MEM_WAIT_CYC > 0) begin : g_mem_wait
      localparam int CNT_W = $clog2(MEM_WAIT_CYC + 1);
      mem_state_e       state, state_nxt;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic             mem_op;

      assign mem_op = ex_mem.valid && (ex_mem.memread || ex_mem.memwrite);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state <= M_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // The entry cycle counts as the first wait cycle, so the count starts one short.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_hold  = 1'b0;
        case (state)
          M_IDLE: if (mem_op) begin
            mem_hold  = 1'b1;
            cnt_nxt   = CNT_W'(MEM_WAIT_CYC - 1);
            state_nxt = M_WAIT;
          end
          M_WAIT: if (cnt != '0) begin
            mem_hold = 1'b1;
            cnt_nxt  = cnt - 1'b1;
          end else begin
            state_nxt = M_IDLE;
          end
          default: state_nxt = M_IDLE;
        endcase
      end
    end else begin : g_no_wait
      assign mem_hold = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex     <= CTRL_BUBBLE;
      id_ex_rd  <= '0;
      ex_mem    <= '0;
      ex_mem_rd <= '0;
      mem_wb    <= '0;
      mem_wb_rd <= '0;
    end else if (mem_hold) begin
      mem_wb    <= '0;
      mem_wb_rd <= '0;
    end else begin
      mem_wb    <= '{valid: ex_mem.valid, memtoreg: ex_mem.memtoreg, regwrite: ex_mem.regwrite};
      mem_wb_rd <= ex_mem_rd;
      ex_mem    <= '{valid: id_ex.valid, memread: id_ex.memread, memwrite: id_ex.memwrite,
                     memtoreg: id_ex.memtoreg, regwrite: id_ex.regwrite};
      ex_mem_rd <= id_ex_rd;
      if (flush || load_use) begin
        id_ex    <= CTRL_BUBBLE;
        id_ex_rd <= '0;
      end else begin
        id_ex    <= dec_ctrl;
        id_ex_rd <= dec_ctrl.valid ? id_rd : '0;
      end
    end
  end

  assign ex_valid     = id_ex.valid;
  assign ex_alusrc    = id_ex.alusrc;
  assign ex_branch    = id_ex.branch;
  assign ex_jump      = id_ex.jump;
  assign ex_aluop     = id_ex.aluop;
  assign ex_rd        = id_ex_rd;
  assign mem_valid    = ex_mem.valid;
  assign mem_memread  = ex_mem.memread;
  assign mem_memwrite = ex_mem.memwrite;
  assign mem_memtoreg = ex_mem.memtoreg;
  assign mem_regwrite = ex_mem.regwrite;
  assign mem_rd       = ex_mem_rd;
  assign wb_valid     = mem_wb.valid;
  assign wb_regwrite  = mem_wb.regwrite;
  assign wb_memtoreg  = mem_wb.memtoreg;
  assign wb_rd        = mem_wb_rd;

endmodule
